// File: rtl/gat_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gat_pkg
// Purpose  : Shared types and width helpers for the GAT num_node datapath.
//            - num_node_rd_state_e : reader pass state
//            - num_node_width()    : width of a per-subgraph node count
//            - num_node_addr_w()   : width of a num_node BRAM address
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package gat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } num_node_rd_state_e;

  // Width of a node count for subgraphs holding up to max_nodes nodes.
  function automatic int num_node_width(input int max_nodes);
    return (max_nodes > 1) ? $clog2(max_nodes) : 1;
  endfunction

  // Address width of a BRAM holding num_subgraphs entries.
  function automatic int num_node_addr_w(input int num_subgraphs);
    return (num_subgraphs > 1) ? $clog2(num_subgraphs) : 1;
  endfunction

endpackage : gat_pkg
`default_nettype wire

// File: rtl/num_node_prefetch_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : num_node_prefetch_fifo
// Purpose  : Small show-ahead FIFO. The head entry is visible on o_data
//            whenever o_empty is low; i_pop consumes it. Push and pop in the
//            same cycle leave the count unchanged. The writer side never
//            pushes when full (guaranteed by the caller's credit check).
// Ports    : clk, rst_n (async, active-low)
//            i_push, i_data  - write side
//            i_pop           - consume head (ignored when empty)
//            o_data, o_empty - head entry and empty flag
//            o_count         - current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module num_node_prefetch_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the empty flag qualifies the head.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

endmodule : num_node_prefetch_fifo
`default_nettype wire

// File: rtl/num_node_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : num_node_reader
// Purpose  : Streams each subgraph's node count from the num_node BRAM, in
//            subgraph order, to the softmax/aggregator stage over valid/ready.
//            Reads never pass the writer's committed entry count, and BRAM
//            latency is hidden by a small prefetch FIFO.
// Ports    : clk, rst_n (async, active-low)
//            start_i              - pulse, begin a pass from address 0
//            wr_addr_i, wr_done_i - writer progress
//            num_node_bram_*      - BRAM port B (enb, addrb, doutb)
//            num_node_o/_vld_o/_rdy_i, last_o - output stream
//            busy_o, done_o       - pass status
// Options  : NUM_NODE_READER_PERF_EN adds perf_dn_stall_o / perf_wr_stall_o
//            (saturating 32-bit stall counters, cleared on accepted start).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module num_node_reader
  import gat_pkg::*;
#(
  parameter int NUM_SUBGRAPHS   = 2708,
  parameter int MAX_NODES       = 168,
  parameter int BRAM_LATENCY    = 2,
  parameter int FIFO_DEPTH      = 4,
  parameter int NUM_NODE_WIDTH  = num_node_width(MAX_NODES),
  parameter int NUM_NODE_ADDR_W = num_node_addr_w(NUM_SUBGRAPHS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [NUM_NODE_ADDR_W-1:0] wr_addr_i,
  input  logic                       wr_done_i,
  output logic                       num_node_bram_enb,
  output logic [NUM_NODE_ADDR_W-1:0] num_node_bram_addrb,
  input  logic [NUM_NODE_WIDTH-1:0]  num_node_bram_doutb,
  output logic [NUM_NODE_WIDTH-1:0]  num_node_o,
  output logic                       num_node_vld_o,
  input  logic                       num_node_rdy_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
`ifdef NUM_NODE_READER_PERF_EN
  ,
  output logic [31:0]                perf_dn_stall_o,
  output logic [31:0]                perf_wr_stall_o
`endif
);

  // One extra bit so the read address can reach NUM_SUBGRAPHS without wrapping.
  localparam int RA_W  = NUM_NODE_ADDR_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + BRAM_LATENCY + 1) + 1;
  localparam logic [RA_W-1:0] c_NUM  = RA_W'(NUM_SUBGRAPHS);
  localparam logic [RA_W-1:0] c_LAST = RA_W'(NUM_SUBGRAPHS - 1);

  num_node_rd_state_e        r_state;
  logic [RA_W-1:0]           r_rd_addr;
  logic [BRAM_LATENCY-1:0]   r_vld_sr;
  logic [BRAM_LATENCY-1:0]   r_last_sr;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_addr_ok;
  logic                      w_wr_ok;
  logic                      w_space;
  logic                      w_issue;
  logic                      w_issue_last;
  logic [OCC_W-1:0]          w_inflight;
  logic [CNT_W-1:0]          w_fifo_count;
  logic                      w_fifo_empty;
  logic [NUM_NODE_WIDTH:0]   w_fifo_head;
  logic                      w_vld;
  logic                      w_accept;

  //----------------------------------------------------------------------------
  // Read issue
  //----------------------------------------------------------------------------
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      w_inflight = w_inflight + OCC_W'(r_vld_sr[i]);
    end
  end

  assign w_addr_ok    = (r_rd_addr < c_NUM);
  assign w_wr_ok      = (r_rd_addr < {1'b0, wr_addr_i}) || wr_done_i;
  // Every read in flight already owns a FIFO slot, so the FIFO cannot overflow.
  assign w_space      = (w_inflight + OCC_W'(w_fifo_count)) < OCC_W'(FIFO_DEPTH);
  assign w_issue      = (r_state == FETCH) && w_addr_ok && w_wr_ok && w_space;
  assign w_issue_last = (r_rd_addr == c_LAST);

  assign num_node_bram_enb   = w_issue;
  assign num_node_bram_addrb = r_rd_addr[NUM_NODE_ADDR_W-1:0];

  //----------------------------------------------------------------------------
  // In-flight tracking: valid and last tag travel alongside the BRAM pipeline
  //----------------------------------------------------------------------------
  generate
    if (BRAM_LATENCY == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_sr  <= '0;
          r_last_sr <= '0;
        end else begin
          r_vld_sr  <= w_issue;
          r_last_sr <= w_issue_last;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_sr  <= '0;
          r_last_sr <= '0;
        end else begin
          r_vld_sr  <= {r_vld_sr[BRAM_LATENCY-2:0], w_issue};
          r_last_sr <= {r_last_sr[BRAM_LATENCY-2:0], w_issue_last};
        end
      end
    end
  endgenerate

  //----------------------------------------------------------------------------
  // Prefetch FIFO: {last, count}
  //----------------------------------------------------------------------------
  num_node_prefetch_fifo #(
    .WIDTH (NUM_NODE_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_vld_sr[BRAM_LATENCY-1]),
    .i_data  ({r_last_sr[BRAM_LATENCY-1], num_node_bram_doutb}),
    .i_pop   (w_accept),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_vld          = !w_fifo_empty;
  assign w_accept       = w_vld && num_node_rdy_i;
  assign num_node_vld_o = w_vld;
  assign num_node_o     = w_vld ? w_fifo_head[NUM_NODE_WIDTH-1:0] : '0;
  assign last_o         = w_vld && w_fifo_head[NUM_NODE_WIDTH];
  assign busy_o         = r_busy;
  assign done_o         = r_done;

  //----------------------------------------------------------------------------
  // Pass control
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state   <= FETCH;
            r_rd_addr <= '0;
            r_busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (w_issue) begin
            r_rd_addr <= r_rd_addr + RA_W'(1);
            if (w_issue_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_accept && last_o) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NUM_NODE_READER_PERF_EN
  //----------------------------------------------------------------------------
  // Stall counters
  //----------------------------------------------------------------------------
  logic [31:0] r_perf_dn_stall;
  logic [31:0] r_perf_wr_stall;
  logic        w_start_acc;
  logic        w_wr_block;

  assign w_start_acc = (r_state == IDLE) && start_i;
  // Blocked by writer progress alone: every other issue condition holds.
  assign w_wr_block  = (r_state == FETCH) && w_addr_ok && w_space && !w_wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_dn_stall <= '0;
      r_perf_wr_stall <= '0;
    end else if (w_start_acc) begin
      r_perf_dn_stall <= '0;
      r_perf_wr_stall <= '0;
    end else begin
      if (w_vld && !num_node_rdy_i && (r_perf_dn_stall != '1))
        r_perf_dn_stall <= r_perf_dn_stall + 32'd1;
      if (w_wr_block && (r_perf_wr_stall != '1))
        r_perf_wr_stall <= r_perf_wr_stall + 32'd1;
    end
  end

  assign perf_dn_stall_o = r_perf_dn_stall;
  assign perf_wr_stall_o = r_perf_wr_stall;
`endif

endmodule : num_node_reader
`default_nettype wire

// File: tb/tb_num_node_reader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_num_node_reader
// Purpose  : Self-checking bench for num_node_reader (8 subgraphs, BRAM
//            latency 2, FIFO depth 4). A BRAM model answers port B; a
//            reference of the pass (expected beat order, writer-committed
//            limit, outstanding-read bound, done timing) checks every cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_num_node_reader;

  localparam int N  = 8;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int NW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic          wr_done_i = 1'b0;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [NW-1:0] doutb;
  logic [NW-1:0] num_node_o;
  logic          vld;
  logic          rdy = 1'b0;
  logic          last;
  logic          busy;
  logic          done;
`ifdef NUM_NODE_READER_PERF_EN
  logic [31:0]   perf_dn;
  logic [31:0]   perf_wr;
`endif

  always #5 clk = ~clk;

  num_node_reader #(
    .NUM_SUBGRAPHS (N),
    .MAX_NODES     (168),
    .BRAM_LATENCY  (L),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .wr_addr_i           (wr_addr_i),
    .wr_done_i           (wr_done_i),
    .num_node_bram_enb   (enb),
    .num_node_bram_addrb (addrb),
    .num_node_bram_doutb (doutb),
    .num_node_o          (num_node_o),
    .num_node_vld_o      (vld),
    .num_node_rdy_i      (rdy),
    .last_o              (last),
    .busy_o              (busy),
    .done_o              (done)
`ifdef NUM_NODE_READER_PERF_EN
    ,
    .perf_dn_stall_o     (perf_dn),
    .perf_wr_stall_o     (perf_wr)
`endif
  );

  // BRAM port B model: data appears L cycles after the enabled cycle.
  logic [NW-1:0] mem  [N];
  logic [NW-1:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= enb ? mem[addrb] : '0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign doutb = pipe[L-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_cnt = 0;

  // Reference state of the current pass
  bit   pass_active = 0;
  int   start_cyc, first_enb, first_vld, done_cyc, last_acc_cyc;
  int   exp_rd, n_reads, n_acc, done_cnt;
  bit   prev_stall = 0;
  logic [NW:0] prev_beat;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic set_writer(input int c);
    wr_cnt    = c;
    wr_addr_i = c[AW-1:0];
    wr_done_i = (c >= N);
  endtask

  // Per-cycle reference check, evaluated mid-cycle.
  task automatic monitor();
    if (!rst_n) begin
      pass_active = 0; prev_stall = 0;
      n_reads = 0; n_acc = 0; exp_rd = 0;
    end else begin
      if (start_i && !pass_active) begin
        pass_active = 1; start_cyc = cyc;
        n_reads = 0; n_acc = 0; exp_rd = 0; done_cnt = 0;
        first_enb = -1; first_vld = -1;
      end
      if (enb) begin
        check("rd_addr", 32'(addrb), exp_rd);
        check("rd_committed", 32'(int'(addrb) < wr_cnt), 1);
        if (first_enb < 0) first_enb = cyc;
        exp_rd++; n_reads++;
      end
      if (vld && first_vld < 0) first_vld = cyc;
      if (prev_stall) check("hold", {vld, last, num_node_o}, {1'b1, prev_beat});
      if (vld && rdy) begin
        check("beat_in_range", 32'(n_acc < N), 1);
        check("beat", 32'(num_node_o), 32'(mem[n_acc % N]));
        check("last", 32'(last), 32'(n_acc == N-1));
        n_acc++; last_acc_cyc = cyc;
      end
      check("no_overflow", 32'((n_reads - n_acc) <= D), 1);
      if (done) begin
        done_cnt++; done_cyc = cyc; pass_active = 0;
        check("done_after_last", cyc - last_acc_cyc, 1);
        check("done_beats", n_acc, N);
      end
      prev_stall = vld && !rdy;
      prev_beat  = {last, num_node_o};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_pass();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin tick(); k++; end
    check("done_timeout", 32'(done_cnt > 0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {enb, addrb, vld, num_node_o, last, busy, done}, '0);
  endtask

  initial begin
    int k;
    mem = '{8'd3, 8'd1, 8'd167, 8'd0, 8'd5, 8'd9, 8'd2, 8'd7};
    for (int i = 0; i < L; i++) pipe[i] = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (6) tick();
    check_all_zero("idle_outputs");

    // Basic stream
    set_writer(N); rdy = 1'b1;
    start_pass();
    wait_done(60);
    check("first_enb_lat", first_enb - start_cyc, 1);
    check("first_vld_lat", first_vld - start_cyc, 4);
    check("last_beat_cyc", last_acc_cyc - start_cyc, 11);
    check("done_cyc", done_cyc - start_cyc, 12);
    check("basic_reads", n_reads, N);
    tick();
    check("done_one_cycle", 32'(done), 0);

    // Backpressure: rdy low for 10 cycles from the first valid beat
    repeat (3) tick();
    start_pass();
    repeat (3) tick();
    rdy = 1'b0;
    repeat (10) tick();
    check("bp_reads", n_reads, D);
    check("bp_head", {vld, num_node_o}, {1'b1, mem[0]});
    check("bp_no_accept", n_acc, 0);
`ifdef NUM_NODE_READER_PERF_EN
    check("perf_dn_stall", perf_dn, 10);
`endif
    rdy = 1'b1;
    wait_done(60);

    // Writer gating
    repeat (3) tick();
    set_writer(2);
    start_pass();
    repeat (20) tick();
    check("gate_reads", n_reads, 2);
    check("gate_beats", n_acc, 2);
    set_writer(7);
    repeat (12) tick();
    check("gate_reads_7", n_reads, 7);
    set_writer(N);
    wait_done(60);

    // Reset mid-pass after three beats
    repeat (3) tick();
    start_pass();
    k = 0;
    while (n_acc < 3 && k < 40) begin tick(); k++; end
    check("mid_beats", n_acc, 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_all_zero("post_reset_idle");
    start_pass();
    wait_done(60);

    // Start pulsed during DRAIN is ignored
    repeat (3) tick();
    start_pass();
    k = 0;
    while (n_reads < N && k < 40) begin tick(); k++; end
    check("drain_busy", {busy, done}, 2'b10);
    start_pass();
    wait_done(60);
    repeat (15) tick();
    check("single_done", done_cnt, 1);
    check("no_restart", n_reads, N);

    // Randomized passes: random data, backpressure and writer progress
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 167));
      set_writer($urandom_range(0, 2));
      rdy = 1'b1;
      repeat (2) tick();
      start_pass();
      k = 0;
      while (done_cnt == 0 && k < 400) begin
        rdy = ($urandom % 4) != 0;
        if (wr_cnt < N && ($urandom % 3) == 0) set_writer(wr_cnt + 1);
        tick();
        k++;
      end
      check("rand_done", 32'(done_cnt > 0), 1);
      check("rand_beats", n_acc, N);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_num_node_reader
`default_nettype wire
